// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit.
// Sequences fetch/decode/execute/memory/writeback over a shared memory port
// with a ready handshake, a per-state memory-wait timeout and a sticky fault.
module multicycle_controller #(
    parameter int MEM_TIMEOUT  = 15,  // 1..255 wait cycles before fault
    parameter bit ENABLE_SHIFT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] inst_i,
    input  logic        mem_ready_i,
    input  logic        alu_zero_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_sel_o,
    output logic        ir_wen_o,
    output logic        pc_wen_o,
    output logic        regfile_wen_o,
    output logic [2:0]  imm_ext_sel_o,
    output logic [1:0]  alu_src_a_sel_o,
    output logic [1:0]  alu_src_b_sel_o,
    output logic [3:0]  alu_fun_o,
    output logic [1:0]  result_sel_o,
    output logic        fault_o,
    output logic        illegal_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       fault_q;
    logic       illegal_q;
    logic       illegal_nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [3:0] exec_fun;
    logic       exec_ok;
    logic       req;
    logic       timeout_hit;

    assign opcode    = inst_i[6:0];
    assign funct3    = inst_i[14:12];
    assign funct7_b5 = inst_i[30];

    // requesting states share one timeout counter; it restarts on every state change
    assign req         = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_hit = req && !mem_ready_i && (wait_cnt == WAIT_LAST);

    // ALU operation for R/I-type execute; sub is only reachable from R-type
    always_comb begin
        exec_fun = ALU_ADD;
        exec_ok  = 1'b1;
        case (funct3)
            3'b000: exec_fun = (opcode[5] && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010: exec_fun = ALU_SLT;
            3'b100: exec_fun = ALU_XOR;
            3'b110: exec_fun = ALU_OR;
            3'b111: exec_fun = ALU_AND;
            3'b001: begin
                if (ENABLE_SHIFT) exec_fun = ALU_SLL;
                else              exec_ok  = 1'b0;
            end
            3'b101: begin
                if (ENABLE_SHIFT) exec_fun = funct7_b5 ? ALU_SRA : ALU_SRL;
                else              exec_ok  = 1'b0;
            end
            default: exec_ok = 1'b0;  // sltu not supported
        endcase
        if (!exec_ok) exec_fun = ALU_ADD;
    end

    // next-state selection; a timeout overrides whatever the wait state chose
    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        case (state)
            S_FETCH:  if (mem_ready_i) state_nxt = S_DECODE;
            S_DECODE: begin
                if (inst_i == 32'd0) begin
                    state_nxt = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:              state_nxt = S_EXECR;
                        OP_I:              state_nxt = S_EXECI;
                        OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                        OP_BRANCH:         state_nxt = S_BRANCH;
                        default: begin
                            state_nxt   = S_FAULT;
                            illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: state_nxt = opcode[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (mem_ready_i) state_nxt = S_FETCH;
            S_EXECR, S_EXECI: begin
                if (exec_ok) begin
                    state_nxt = S_ALUWB;
                end else begin
                    state_nxt   = S_FAULT;
                    illegal_nxt = 1'b1;
                end
            end
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: begin
                if (funct3[2:1] == 2'b00) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt   = S_FAULT;
                    illegal_nxt = 1'b1;
                end
            end
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FAULT;  // unused encodings lock up safely
        endcase
        if (timeout_hit) begin
            state_nxt   = S_FAULT;
            illegal_nxt = 1'b0;
        end
    end

    // state, wait counter and sticky fault flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_FETCH;
            wait_cnt  <= 8'd0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || mem_ready_i || !req) wait_cnt <= 8'd0;
            else                                              wait_cnt <= wait_cnt + 8'd1;
            if ((state_nxt == S_FAULT) && (state != S_FAULT)) begin
                fault_q   <= 1'b1;
                illegal_q <= illegal_nxt;
            end
        end
    end

    // datapath controls decoded from the current state; FETCH enables are
    // gated by reset so nothing is written while rst_ni is low
    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        addr_sel_o      = 1'b0;
        ir_wen_o        = 1'b0;
        pc_wen_o        = 1'b0;
        regfile_wen_o   = 1'b0;
        imm_ext_sel_o   = 3'b000;
        alu_src_a_sel_o = 2'b00;
        alu_src_b_sel_o = 2'b00;
        alu_fun_o       = ALU_ADD;
        result_sel_o    = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req_o       = 1'b1;
                alu_src_a_sel_o = 2'b01;
                alu_src_b_sel_o = 2'b10;
                result_sel_o    = 2'b10;
                ir_wen_o        = mem_ready_i && rst_ni;
                pc_wen_o        = mem_ready_i && rst_ni;
            end
            S_DECODE: begin
                alu_src_a_sel_o = 2'b10;
                alu_src_b_sel_o = 2'b01;
                imm_ext_sel_o   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_b_sel_o = 2'b01;
                imm_ext_sel_o   = opcode[5] ? 3'b001 : 3'b000;
            end
            S_MEMRD: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
            end
            S_MEMWB: begin
                regfile_wen_o = 1'b1;
                result_sel_o  = 2'b01;
            end
            S_MEMWR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                addr_sel_o = 1'b1;
            end
            S_EXECR: alu_fun_o = exec_fun;
            S_EXECI: begin
                alu_src_b_sel_o = 2'b01;
                alu_fun_o       = exec_fun;
            end
            S_ALUWB: regfile_wen_o = 1'b1;
            S_BRANCH: begin
                alu_fun_o = ALU_SUB;
                case (funct3)
                    3'b000:  pc_wen_o = alu_zero_i;
                    3'b001:  pc_wen_o = !alu_zero_i;
                    default: pc_wen_o = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    assign fault_o   = fault_q;
    assign illegal_o = illegal_q;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded
// into the expected state walk (with chosen ready delays) and every cycle's
// controls are compared against a table built from the state definitions.
module tb_multicycle_controller;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_req, mem_we, addr_sel, ir_wen, pc_wen, rf_wen;
    logic [2:0]  imm_sel;
    logic [1:0]  a_sel, b_sel, res_sel;
    logic [3:0]  alu_fun;
    logic        fault, illegal;
    logic [3:0]  state;

    multicycle_controller #(.MEM_TIMEOUT(TO), .ENABLE_SHIFT(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .inst_i(inst), .mem_ready_i(mem_ready),
        .alu_zero_i(alu_zero), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .addr_sel_o(addr_sel), .ir_wen_o(ir_wen), .pc_wen_o(pc_wen),
        .regfile_wen_o(rf_wen), .imm_ext_sel_o(imm_sel),
        .alu_src_a_sel_o(a_sel), .alu_src_b_sel_o(b_sel), .alu_fun_o(alu_fun),
        .result_sel_o(res_sel), .fault_o(fault), .illegal_o(illegal),
        .state_o(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { int st; bit rdy; } step_t;
    step_t seq[$];
    bit    exp_ill;

    logic [21:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_wen, pc_wen, rf_wen, imm_sel,
                  a_sel, b_sel, alu_fun, res_sel, fault, illegal};

    function automatic logic [3:0] ref_fun(input logic [31:0] ins);
        case (ins[14:12])
            3'd0:    return (ins[5] && ins[30]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd4:    return 4'd3;
            3'd5:    return ins[30] ? 4'd8 : 4'd7;
            3'd6:    return 4'd4;
            3'd7:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    // expected controls for a state, straight from the per-state output table
    function automatic logic [21:0] exp_ctrl(input int st, input logic [31:0] ins,
                                             input bit rdy, input bit z, input bit ill);
        logic mr = 0, we = 0, as = 0, irw = 0, pcw = 0, rfw = 0, flt = 0, il = 0;
        logic [2:0] im = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic [3:0] fn = 0;
        case (st)
            0:  begin mr = 1; a = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            1:  begin a = 2; b = 1; im = 2; end
            2:  begin b = 1; im = ins[5] ? 3'd1 : 3'd0; end
            3:  begin mr = 1; as = 1; end
            4:  begin rfw = 1; rs = 1; end
            5:  begin mr = 1; we = 1; as = 1; end
            6:  fn = ref_fun(ins);
            7:  begin b = 1; fn = ref_fun(ins); end
            8:  rfw = 1;
            9:  begin
                    fn = 1;
                    if (ins[14:12] == 3'd0)      pcw = z;
                    else if (ins[14:12] == 3'd1) pcw = !z;
                end
            15: begin flt = 1; il = ill; end
            default: ;
        endcase
        return {mr, we, as, irw, pcw, rfw, im, a, b, fn, rs, flt, il};
    endfunction

    // a wait state held w cycles before ready; gives up to FAULT after TO
    function automatic bit add_wait(input int st, input int w);
        for (int i = 0; i < TO; i++) begin
            seq.push_back('{st, (i == w)});
            if (i == w) return 1'b1;
        end
        seq.push_back('{15, 1'($urandom_range(0, 1))});
        return 1'b0;
    endfunction

    function automatic void push(input int st);
        seq.push_back('{st, 1'($urandom_range(0, 1))});
    endfunction

    // expected state walk for one instruction
    function automatic void plan(input logic [31:0] ins, input int fw, input int mw);
        logic [2:0] f3;
        f3 = ins[14:12];
        seq.delete();
        exp_ill = 1'b0;
        if (!add_wait(0, fw)) return;
        push(1);
        if (ins == 32'd0) return;
        case (ins[6:0])
            7'h33, 7'h13: begin
                push(ins[6:0] == 7'h33 ? 6 : 7);
                if (f3 == 3'd3) begin push(15); exp_ill = 1'b1; end
                else push(8);
            end
            7'h03: begin push(2); if (add_wait(3, mw)) push(4); end
            7'h23: begin push(2); void'(add_wait(5, mw)); end
            7'h63: begin
                push(9);
                if (f3 > 3'd1) begin push(15); exp_ill = 1'b1; end
            end
            default: begin push(15); exp_ill = 1'b1; end
        endcase
    endfunction

    // hold async reset low and check its effect immediately; leaves the bench
    // just after a rising edge with the DUT in FETCH and a fresh counter
    task automatic do_reset();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_fault", {fault, illegal}, 0);
        chk("rst_wen", {ir_wen, pc_wen, rf_wen, mem_we}, 0);
        chk("rst_req", mem_req, 1);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // drive the planned walk (up to limit steps), checking every cycle
    task automatic run(input logic [31:0] ins, input bit z, input int limit);
        int n;
        n = (limit < seq.size()) ? limit : seq.size();
        for (int i = 0; i < n; i++) begin
            inst = ins; mem_ready = seq[i].rdy; alu_zero = z;
            @(negedge clk);
            chk($sformatf("state_%0d", i), state, seq[i].st);
            chk($sformatf("ctl_s%0d_i%08h", seq[i].st, ins), obs,
                exp_ctrl(seq[i].st, ins, seq[i].rdy, z, exp_ill));
            @(posedge clk); #1;
        end
        if (n == seq.size() && seq[n-1].st == 15) begin
            for (int k = 0; k < 3; k++) begin
                mem_ready = 1'b1;
                @(negedge clk);
                chk("fault_hold_state", state, 15);
                chk("fault_hold_ctl", obs, exp_ctrl(15, ins, 1, z, exp_ill));
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return $urandom_range(0, 2);
        if (r < 16) return $urandom_range(3, TO - 1);
        if (r < 18) return TO - 1;
        return TO;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 7))
            0, 7: begin ins[6:0] = 7'h33; ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4: begin
                ins[6:0] = 7'h63;
                if ($urandom_range(0, 1) == 1) ins[14:13] = 2'b00;
            end
            5: ins = 32'd0;
            default: begin
                while (ins == 32'd0 || ins[6:0] == 7'h33 || ins[6:0] == 7'h13 ||
                       ins[6:0] == 7'h03 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63)
                    ins = $urandom;
            end
        endcase
        return ins;
    endfunction

    logic [31:0] d_ins [14] = '{32'h002081B3, 32'h402081B3, 32'h40008193, 32'h4010D193,
                                32'h0000A183, 32'h0030A023, 32'h00208463, 32'h00208463,
                                32'h00209463, 32'h00209463, 32'h0000007F, 32'h002081B3,
                                32'h002081B3, 32'h0000A183};
    int d_fw [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, TO, TO - 1, 0};
    int d_mw [14] = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, TO};
    bit d_z  [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        rst_n = 1'b0; inst = 32'd0; mem_ready = 1'b0; alu_zero = 1'b0;
        #2;
        chk("init_state", state, 0);
        chk("init_ctl", obs, exp_ctrl(0, 32'd0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            plan(d_ins[i], d_fw[i], d_mw[i]);
            run(d_ins[i], d_z[i], 1000);
        end

        // reset pulsed mid-MEMRD abandons the load at once
        plan(32'h0000A183, 0, 10);
        run(32'h0000A183, 1'b0, 5);
        do_reset();
        inst = 32'h002081B3;
        @(negedge clk);
        chk("post_rst_state", state, 0);
        @(posedge clk); #1;

        for (int t = 0; t < 300; t++) begin
            logic [31:0] ins;
            ins = rand_inst();
            plan(ins, pick_wait(), pick_wait());
            run(ins, 1'($urandom_range(0, 1)), 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
